// File: rtl/vita49_pack_if.sv
// -----------------------------------------------------------------------------
// vita49_pack_if
// Purpose : AXI4-Stream style bundle used for both the raw sample input and
//           the VITA49 packet output of vita49_pack.
// Signals : tdata  [31:0] data word
//           tvalid        source has a word
//           tready        sink accepts the word
//           tlast         last word of a packet
// Modports: master drives tdata/tvalid/tlast and reads tready;
//           slave reads tdata/tvalid/tlast and drives tready.
// -----------------------------------------------------------------------------
interface vita49_pack_if;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/vita49_pack.sv
// -----------------------------------------------------------------------------
// vita49_pack
// Purpose : Wraps a raw 32-bit sample stream into VITA49 signal-data packets:
//           header, stream ID, integer seconds, fractional seconds (msw, lsw),
//           then payload_len sample words with TLAST on the final one.
// Ports   : AXIS_ACLK       clock
//           AXIS_ARESETN    asynchronous active-low reset
//           S_AXIS          raw sample stream (slave)
//           M_AXIS          VITA49 packet stream (master)
//           trig            start qualifier (with ctrl[0])
//           ctrl            [0] start_cmd, [1] reset_cmd, [2] passthrough
//           streamID        stream identifier, latched per packet
//           payload_len     payload words per packet, latched per packet
//           timestamp_sec   integer timestamp, latched per packet
//           timestamp_fsec  fractional timestamp, latched per packet
//           status          {start,reset,pass,ARESETN,23'h0,len_err,state}
//           pkt_sent        packets completed (wraps)
//           len_err_cnt     rejected payload lengths (wraps)
//           Mstate_dbg      current state
// -----------------------------------------------------------------------------
module vita49_pack (
    input  logic                 AXIS_ACLK,
    input  logic                 AXIS_ARESETN,
    vita49_pack_if.slave         S_AXIS,
    vita49_pack_if.master        M_AXIS,
    input  logic                 trig,
    input  logic [31:0]          ctrl,
    input  logic [31:0]          streamID,
    input  logic [15:0]          payload_len,
    input  logic [31:0]          timestamp_sec,
    input  logic [63:0]          timestamp_fsec,
    output logic [31:0]          status,
    output logic [31:0]          pkt_sent,
    output logic [31:0]          len_err_cnt,
    output logic [3:0]           Mstate_dbg
);
    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_WAIT    = 4'd1,
        S_HDR     = 4'd2,
        S_SID     = 4'd3,
        S_TSI     = 4'd4,
        S_TSF0    = 4'd5,
        S_TSF1    = 4'd6,
        S_PAYLOAD = 4'd7
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [3:0]  r_pkt_cnt;
    logic [31:0] r_pkt_sent;
    logic [31:0] r_len_err_cnt;
    logic        r_len_err;
    logic        r_err_done;     // length error already counted for this WAIT_DATA visit
    logic [31:0] r_sid;
    logic [31:0] r_ts_sec;
    logic [63:0] r_ts_fsec;
    logic [15:0] r_len;
    logic [15:0] r_pay_cnt;

    logic        w_start;
    logic        w_rcmd;
    logic        w_pass;
    logic        w_len_bad;
    logic        w_pay_xfer;
    logic        w_pay_last;
    logic [15:0] w_pkt_size;
    logic [31:0] w_hdr;
    logic        w_latch;
    logic        w_err_pulse;
    logic        w_pkt_done;
    logic [31:0] w_m_tdata;
    logic        w_m_tvalid;
    logic        w_m_tlast;
    logic        w_s_tready;
    logic        w_unused_ctrl;

    assign w_start       = ctrl[0];
    assign w_rcmd        = ctrl[1];
    assign w_pass        = ctrl[2];
    assign w_unused_ctrl = ^ctrl[31:3];

    assign w_len_bad  = (payload_len == 16'd0) || (payload_len > 16'd65530);
    assign w_pay_xfer = (r_state == S_PAYLOAD) && S_AXIS.tvalid && M_AXIS.tready;
    assign w_pay_last = (r_pay_cnt == (r_len - 16'd1));
    assign w_pkt_size = r_len + 16'd5;
    // Version 1 = signal data with stream ID; TSI=UTC, TSF=real-time
    assign w_hdr      = {4'b0001, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, r_pkt_cnt, w_pkt_size};

    always_comb begin
        w_state_next = r_state;
        w_latch      = 1'b0;
        w_err_pulse  = 1'b0;
        w_pkt_done   = 1'b0;
        w_m_tdata    = 32'h0;
        w_m_tvalid   = 1'b0;
        w_m_tlast    = 1'b0;
        w_s_tready   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_start && trig) w_state_next = S_WAIT;
            end
            S_WAIT: begin
                // A bad length blocks the start; the first sample stays queued upstream
                if (w_len_bad) begin
                    w_err_pulse = !r_err_done;
                end else if (S_AXIS.tvalid) begin
                    w_latch      = 1'b1;
                    w_state_next = S_HDR;
                end
            end
            S_HDR: begin
                w_m_tvalid = 1'b1;
                w_m_tdata  = w_hdr;
                if (M_AXIS.tready) w_state_next = S_SID;
            end
            S_SID: begin
                w_m_tvalid = 1'b1;
                w_m_tdata  = r_sid;
                if (M_AXIS.tready) w_state_next = S_TSI;
            end
            S_TSI: begin
                w_m_tvalid = 1'b1;
                w_m_tdata  = r_ts_sec;
                if (M_AXIS.tready) w_state_next = S_TSF0;
            end
            S_TSF0: begin
                w_m_tvalid = 1'b1;
                w_m_tdata  = r_ts_fsec[63:32];
                if (M_AXIS.tready) w_state_next = S_TSF1;
            end
            S_TSF1: begin
                w_m_tvalid = 1'b1;
                w_m_tdata  = r_ts_fsec[31:0];
                if (M_AXIS.tready) w_state_next = S_PAYLOAD;
            end
            S_PAYLOAD: begin
                // Samples flow straight through; no buffering
                w_m_tdata  = S_AXIS.tdata;
                w_m_tvalid = S_AXIS.tvalid;
                w_s_tready = M_AXIS.tready;
                w_m_tlast  = w_pay_last;
                if (w_pay_xfer && w_pay_last) begin
                    w_pkt_done   = 1'b1;
                    w_state_next = w_start ? S_WAIT : S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase

        if (w_pass) begin
            w_state_next = S_IDLE;
            w_latch      = 1'b0;
            w_err_pulse  = 1'b0;
            w_pkt_done   = 1'b0;
            w_m_tdata    = S_AXIS.tdata;
            w_m_tvalid   = S_AXIS.tvalid;
            w_m_tlast    = S_AXIS.tlast;
            w_s_tready   = M_AXIS.tready;
        end

        // reset_cmd wins over everything; an in-flight packet just stops
        if (w_rcmd) begin
            w_state_next = S_IDLE;
            w_latch      = 1'b0;
            w_err_pulse  = 1'b0;
            w_pkt_done   = 1'b0;
        end
    end

    always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
        if (!AXIS_ARESETN) begin
            r_state       <= S_IDLE;
            r_pkt_cnt     <= 4'd0;
            r_pkt_sent    <= 32'd0;
            r_len_err_cnt <= 32'd0;
            r_len_err     <= 1'b0;
            r_err_done    <= 1'b0;
            r_sid         <= 32'd0;
            r_ts_sec      <= 32'd0;
            r_ts_fsec     <= 64'd0;
            r_len         <= 16'd0;
            r_pay_cnt     <= 16'd0;
        end else begin
            r_state <= w_state_next;

            if (w_rcmd) begin
                r_pkt_cnt     <= 4'd0;
                r_pkt_sent    <= 32'd0;
                r_len_err_cnt <= 32'd0;
                r_len_err     <= 1'b0;
                r_err_done    <= 1'b0;
            end else begin
                if (w_pkt_done) begin
                    r_pkt_cnt  <= r_pkt_cnt + 4'd1;
                    r_pkt_sent <= r_pkt_sent + 32'd1;
                end
                if (w_err_pulse) begin
                    r_len_err_cnt <= r_len_err_cnt + 32'd1;
                    r_len_err     <= 1'b1;
                end
                // Cleared whenever we are outside WAIT_DATA so each entry counts once
                r_err_done <= (r_state == S_WAIT) && (r_err_done || w_err_pulse);
            end

            if (w_latch) begin
                r_sid     <= streamID;
                r_ts_sec  <= timestamp_sec;
                r_ts_fsec <= timestamp_fsec;
                r_len     <= payload_len;
                r_pay_cnt <= 16'd0;
            end else if (w_pay_xfer) begin
                r_pay_cnt <= r_pay_cnt + 16'd1;
            end
        end
    end

    assign M_AXIS.tdata  = w_m_tdata;
    assign M_AXIS.tvalid = w_m_tvalid;
    assign M_AXIS.tlast  = w_m_tlast;
    assign S_AXIS.tready = w_s_tready;

    assign status      = {w_start, w_rcmd, w_pass, AXIS_ARESETN, 23'h0, r_len_err, r_state};
    assign pkt_sent    = r_pkt_sent;
    assign len_err_cnt = r_len_err_cnt;
    assign Mstate_dbg  = r_state;
endmodule
